// File: rtl/br_resolve_queue.sv
// Branch resolution queue: pairs fetch-time predictions with execute outcomes,
// trains the predictor and redirects fetch on a mispredict. Stats: BR_RESOLVE_STATS_EN.
module br_resolve_queue #(
  parameter int s_depth = 8,
  parameter int s_cnt_w = $clog2(s_depth) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq_valid,
  input  logic [31:0]        enq_pc,
  input  logic               enq_pred_take,
  input  logic [31:0]        enq_pred_target,
  output logic               enq_ready,
  input  logic               res_valid,
  input  logic               res_br_en,
  input  logic [31:0]        res_target,
  input  logic               flush,
  output logic               update,
  output logic               br_en,
  output logic [31:0]        i_addr_update,
  output logic               mispredict,
  output logic [31:0]        redirect_pc,
  output logic [s_cnt_w-1:0] count,
  output logic [31:0]        stat_total,
  output logic [31:0]        stat_miss
);

  localparam int aw = $clog2(s_depth);

  logic [31:0]        pc_mem   [s_depth];
  logic               take_mem [s_depth];
  logic [31:0]        tgt_mem  [s_depth];

  logic [s_cnt_w-1:0] head;
  logic [s_cnt_w-1:0] tail;
  logic [aw-1:0]      head_idx;
  logic [aw-1:0]      tail_idx;

  logic               res_acc;
  logic               miss_now;
  logic               enq_acc;
  logic [31:0]        head_pc;
  logic               head_take;
  logic [31:0]        head_tgt;
  logic [31:0]        redir_now;

  assign head_idx  = head[aw-1:0];
  assign tail_idx  = tail[aw-1:0];
  assign count     = tail - head;
  assign enq_ready = (count != s_cnt_w'(s_depth));

  assign head_pc   = pc_mem[head_idx];
  assign head_take = take_mem[head_idx];
  assign head_tgt  = tgt_mem[head_idx];

  // Resolve / mispredict / enqueue qualification with flush priority.
  always_comb begin
    res_acc   = 1'b0;
    miss_now  = 1'b0;
    enq_acc   = 1'b0;
    redir_now = res_br_en ? res_target : head_pc + 32'd4;
    if (!flush) begin
      res_acc = res_valid && (count != '0);
      if (res_acc) begin
        miss_now = (head_take != res_br_en) ||
                   (head_take && res_br_en &&
                    (head_tgt != res_target));
      end
      // Same-cycle enqueue behind a mispredict is wrong-path work.
      enq_acc = enq_valid && enq_ready && !miss_now;
    end
  end

  // Entry storage; written only at the tail on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (enq_acc) begin
      pc_mem[tail_idx]   <= enq_pc;
      take_mem[tail_idx] <= enq_pred_take;
      tgt_mem[tail_idx]  <= enq_pred_target;
    end
  end

  // Head/tail pointers; flush and mispredict both empty the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush || miss_now) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (res_acc) head <= head + 1'b1;
      if (enq_acc) tail <= tail + 1'b1;
    end
  end

  // Registered training and redirect pulses; data holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      update        <= 1'b0;
      mispredict    <= 1'b0;
      br_en         <= 1'b0;
      i_addr_update <= '0;
      redirect_pc   <= '0;
    end else begin
      update     <= res_acc;
      mispredict <= miss_now;
      if (res_acc) begin
        br_en         <= res_br_en;
        i_addr_update <= head_pc;
      end
      if (miss_now) redirect_pc <= redir_now;
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  // Saturating resolve and mispredict counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total <= '0;
      stat_miss  <= '0;
    end else begin
      if (res_acc && stat_total != 32'hFFFF_FFFF)
        stat_total <= stat_total + 32'd1;
      if (miss_now && stat_miss != 32'hFFFF_FFFF)
        stat_miss <= stat_miss + 32'd1;
    end
  end
`else
  assign stat_total = '0;
  assign stat_miss  = '0;
`endif

endmodule

// File: tb/tb_br_resolve_queue.sv
// Randomized and directed bench for br_resolve_queue against a
// queue-based reference model of the resolution rules.
module tb_br_resolve_queue;

  localparam int depth = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_pc;
  logic        enq_pred_take;
  logic [31:0] enq_pred_target;
  logic        enq_ready;
  logic        res_valid;
  logic        res_br_en;
  logic [31:0] res_target;
  logic        flush;
  logic        update;
  logic        br_en;
  logic [31:0] i_addr_update;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
  logic [31:0] stat_total;
  logic [31:0] stat_miss;

  br_resolve_queue #(.s_depth(depth)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_pc(enq_pc),
    .enq_pred_take(enq_pred_take),
    .enq_pred_target(enq_pred_target),
    .enq_ready(enq_ready),
    .res_valid(res_valid), .res_br_en(res_br_en),
    .res_target(res_target), .flush(flush),
    .update(update), .br_en(br_en),
    .i_addr_update(i_addr_update),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .count(count), .stat_total(stat_total),
    .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        take;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  logic        m_update, m_mis, m_br_en;
  logic [31:0] m_iaddr, m_redir, m_total, m_miss;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Reference model: one edge's effect from the rules.
  task automatic model_edge();
    ent_t e;
    int   sz0;
    logic mis;
    if (rst) begin
      q.delete();
      m_update = 0; m_mis = 0; m_br_en = 0;
      m_iaddr = 0; m_redir = 0; m_total = 0; m_miss = 0;
      return;
    end
    m_update = 0;
    m_mis    = 0;
    if (flush) begin
      q.delete();
      return;
    end
    sz0 = q.size();
    mis = 0;
    if (res_valid && sz0 > 0) begin
      e = q.pop_front();
      m_update = 1;
      m_br_en  = res_br_en;
      m_iaddr  = e.pc;
      if (m_total != 32'hFFFF_FFFF) m_total++;
      if (e.take != res_br_en) mis = 1;
      else if (e.take && e.tgt != res_target) mis = 1;
      if (mis) begin
        m_mis   = 1;
        m_redir = res_br_en ? res_target : e.pc + 32'd4;
        if (m_miss != 32'hFFFF_FFFF) m_miss++;
        q.delete();
      end
    end
    if (enq_valid && sz0 < depth && !mis) begin
      e.pc = enq_pc; e.take = enq_pred_take; e.tgt = enq_pred_target;
      q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(q.size()));
    check("enq_ready", 32'(enq_ready), 32'(q.size() != depth));
    check("update", 32'(update), 32'(m_update));
    check("mispredict", 32'(mispredict), 32'(m_mis));
    check("br_en", 32'(br_en), 32'(m_br_en));
    check("i_addr_update", i_addr_update, m_iaddr);
    check("redirect_pc", redirect_pc, m_redir);
`ifdef BR_RESOLVE_STATS_EN
    check("stat_total", stat_total, m_total);
    check("stat_miss", stat_miss, m_miss);
`else
    check("stat_total", stat_total, 32'd0);
    check("stat_miss", stat_miss, 32'd0);
`endif
  endtask

  task automatic step(input logic r, input logic ev,
                      input logic [31:0] pc, input logic tk,
                      input logic [31:0] tg, input logic rv,
                      input logic rb, input logic [31:0] rt,
                      input logic fl);
    rst = r; enq_valid = ev; enq_pc = pc;
    enq_pred_take = tk; enq_pred_target = tg;
    res_valid = rv; res_br_en = rb; res_target = rt; flush = fl;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enq(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg);
    step(0, 1, pc, tk, tg, 0, 0, 0, 0);
  endtask

  task automatic res(input logic rb, input logic [31:0] rt);
    step(0, 0, 0, 0, 0, 1, rb, rt, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(enq_ready), 32'd1);

    // Correctly predicted taken branch.
    enq(32'h100, 1, 32'h200);
    res(1, 32'h200);
    check("t1_update", 32'(update), 32'd1);
    check("t1_iaddr", i_addr_update, 32'h100);
    check("t1_mis", 32'(mispredict), 32'd0);
    check("t1_count", 32'(count), 32'd0);
    idle();

    // Mispredict drops younger entries and a same-cycle enqueue.
    enq(32'h100, 0, 32'h0);
    enq(32'h104, 0, 32'h0);
    enq(32'h108, 0, 32'h0);
    step(0, 1, 32'h10C, 0, 0, 1, 1, 32'h40, 0);
    check("t2_mis", 32'(mispredict), 32'd1);
    check("t2_redir", redirect_pc, 32'h40);
    check("t2_count", 32'(count), 32'd0);
    idle();

    // Not-taken fallthrough wraps past 2^32.
    enq(32'hFFFF_FFFC, 1, 32'h80);
    res(0, 32'h0);
    check("t3_redir", redirect_pc, 32'h0);
    check("t3_mis", 32'(mispredict), 32'd1);

    // Fill, overfill, drain in order, twice for pointer wrap.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < depth; i++)
        enq(32'h1000 + 32'(i * 4), 0, 0);
      check("fill_ready", 32'(enq_ready), 32'd0);
      step(0, 1, 32'hDEAD, 0, 0, 1, 0, 0, 0);
      check("full_enq_drop", 32'(count), 32'(depth - 1));
      for (int i = 1; i < depth; i++) begin
        res(0, 0);
        check("drain_pc", i_addr_update, 32'h1000 + 32'(i * 4));
      end
      idle();
    end

    // Flush beats resolve; resolve on empty is ignored.
    enq(32'h300, 0, 0);
    enq(32'h304, 0, 0);
    enq(32'h308, 0, 0);
    step(0, 1, 32'h30C, 0, 0, 1, 0, 0, 1);
    check("flush_update", 32'(update), 32'd0);
    check("flush_count", 32'(count), 32'd0);
    res(1, 32'h500);
    check("empty_res", 32'(update), 32'd0);

    // Counters: 5 resolves, 2 mispredicted.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      enq(32'h700 + 32'(i * 4), 1, 32'h900);
      res(1, (i < 2) ? 32'h904 : 32'h900);
    end
    idle();
`ifdef BR_RESOLVE_STATS_EN
    check("stat5_total", stat_total, 32'd5);
    check("stat5_miss", stat_miss, 32'd2);
`else
    check("stat5_total", stat_total, 32'd0);
    check("stat5_miss", stat_miss, 32'd0);
`endif

    // Randomized traffic; resolves usually match the oldest prediction.
    for (int n = 0; n < 3000; n++) begin
      logic        r, ev, tk, rv, rb, fl;
      logic [31:0] pc, tg, rt;
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 39) == 0);
      ev = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      pc = {$urandom_range(0, 255), 2'b00};
      tk = $urandom_range(0, 1);
      tg = {$urandom_range(0, 15), 4'h0};
      rb = $urandom_range(0, 1);
      rt = {$urandom_range(0, 15), 4'h0};
      if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
        rb = q[0].take;
        rt = q[0].tgt;
      end
      step(r, ev, pc, tk, tg, rv, rb, rt, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/br_resolve_queue.md
# br_resolve_queue

Resolution-side companion to the branch predictor. Records each prediction issued at fetch in a program-ordered queue. When execute resolves a branch, it compares the actual outcome against the oldest recorded prediction. It then drives the predictor's training port (`update`, `br_en`, `i_addr_update`) and issues a mispredict redirect that discards all younger, wrong-path entries.

## Interface
Parameters:
- `s_depth`, 8: queue entries; power of two, ≥2
- `s_cnt_w`, `$clog2(s_depth)+1`: occupancy width

Ports:
- Clock and reset (one clock; reset is synchronous and active-high):
  - `clk`  in  1  clock
  - `rst`  in  1  synchronous, active-high reset
- Enqueue (fetch side):
  - `enq_valid`  in  1  fetch produced a branch prediction this cycle
  - `enq_pc`  in  32  branch PC
  - `enq_pred_take`  in  1  predicted direction
  - `enq_pred_target`  in  32  predicted target (don't-care when not taken)
  - `enq_ready`  out  1  queue not full (combinational from occupancy)
- Resolve and flush (execute side):
  - `res_valid`  in  1  execute resolved the oldest branch this cycle
  - `res_br_en`  in  1  actual direction
  - `res_target`  in  32  actual taken target
  - `flush`  in  1  external pipeline flush (exception/trap)
- Predictor training and redirect:
  - `update`  out  1  one-cycle predictor training pulse
  - `br_en`  out  1  actual direction to predictor
  - `i_addr_update`  out  32  PC of the trained branch
  - `mispredict`  out  1  one-cycle redirect pulse
  - `redirect_pc`  out  32  correct fetch PC, valid with `mispredict`
- Status and statistics:
  - `count`  out  `s_cnt_w`  current occupancy
  - `stat_total`  out  32  resolved-branch counter (see Configuration)
  - `stat_miss`  out  32  mispredict counter (see Configuration)

## Operation
- Storage: circular buffer of `s_depth` entries `{pc, pred_take, pred_target}`.
  - Head and tail pointers are `s_cnt_w` bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2·`s_depth`.
- Enqueue is accepted when `enq_valid && enq_ready`.
  - A full queue rejects enqueue even if a dequeue occurs the same cycle.
- Resolve is accepted when `res_valid && count != 0`. It consumes the head entry.
  - `res_valid` on an empty queue is ignored: no pulse, no state change.
- Mispredict condition, evaluated at resolve:
  - `pred_take != res_br_en`, or
  - `pred_take && res_br_en && pred_target != res_target`.
- Redirect target: `res_br_en ? res_target : pc + 32'd4`. Addition is mod 2^32.
- On accepted resolve, the registered outputs are:
  - `update` = 1, `br_en` = `res_br_en`, `i_addr_update` = head pc.
  - If mispredicted, additionally `mispredict` = 1 and `redirect_pc` as above.
- Mispredict flush: on the accepting edge the head entry is consumed and all other entries are discarded, leaving `count` = 0.
  - A same-cycle enqueue is dropped, because it is on the wrong path.
- Priority: `rst` > `flush` > resolve/mispredict > enqueue.
  - `flush` empties the queue and suppresses any same-cycle resolve and enqueue; no `update` is emitted.
- Without a mispredict, simultaneous enqueue and resolve proceed together and `count` is unchanged.

## Timing
- `update`, `br_en`, `i_addr_update`, `mispredict`, `redirect_pc` are registered. They assert the cycle after the accepting edge and hold for exactly one cycle.
  - Outside a pulse, `update` and `mispredict` are 0; the data outputs hold their last value.
- `enq_ready` = `count != s_depth`, combinational from registered pointers.
- `count` reflects accepted operations one cycle after the edge.
- Back-to-back resolves every cycle are supported, giving one pulse per cycle.
- Reset values: `count` = 0, `enq_ready` = 1, `update` = `mispredict` = `br_en` = 0, `i_addr_update` = `redirect_pc` = 0, both stats = 0.
- Reset mid-operation discards all entries; no pulse follows.

## Configuration
- `BR_RESOLVE_STATS_EN` defined:
  - `stat_total` increments on every accepted resolve.
  - `stat_miss` increments on every mispredict.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared only by `rst`.
  - `flush` does not alter either counter.
- Not defined: counter logic is omitted and `stat_total` / `stat_miss` are tied to 0.

## Test plan
- Reset, enqueue pc 0x100 (taken, target 0x200), resolve `res_br_en`=1, `res_target`=0x200 -> next cycle `update`=1, `br_en`=1, `i_addr_update`=0x100, `mispredict`=0; `count` returns to 0.
- Enqueue 0x100 (not taken), 0x104, 0x108; resolve with `res_br_en`=1, `res_target`=0x40 -> `mispredict`=1, `redirect_pc`=0x40, `count`=0; an enqueue issued in the same cycle is dropped.
- Enqueue pc 0xFFFF_FFFC (taken), resolve not-taken -> `redirect_pc`=0x0 (wrap).
- Fill 8 entries -> `enq_ready`=0; a further enqueue is ignored. Resolve 8 correctly predicted branches -> 8 consecutive `update` pulses with PCs in enqueue order; pointers wrap correctly on a second fill.
- Assert `flush` together with `res_valid` on a 3-entry queue -> no `update`, `count`=0. Assert `res_valid` on an empty queue -> no pulse.
- With `BR_RESOLVE_STATS_EN`: 5 resolves, 2 mispredicted -> `stat_total`=5, `stat_miss`=2. Without the macro both read 0.
